// File: rtl/uart_tx_fifo.sv
// Transmit holding FIFO between host and UART transmitter: circular buffer with registered count and sticky overrun.
// Optional synchronous flush input enabled by defining UART_TXFIFO_FLUSH_EN.
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     baud_clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     overrun_clr,
   input  logic                     Txhr_rd_en,
`ifdef UART_TXFIFO_FLUSH_EN
   input  logic                     tx_flush,
`endif
   output logic [DATA_W-1:0]        tx_data_o,
   output logic                     Txhr_empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   tx_count,
   output logic                     overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              overrun_q, overrun_d;
   logic              flush, push_ok, pop_ok, drop;

`ifdef UART_TXFIFO_FLUSH_EN
   assign flush = tx_flush;
`else
   assign flush = 1'b0;
`endif

   assign Txhr_empty = (count_q == '0);
   assign full       = (count_q == CW'(DEPTH));
   assign tx_count   = count_q;
   assign tx_data_o  = tx_data_q;
   assign overrun    = overrun_q;

   always_comb begin
      // A pop frees a slot in the same cycle, so a push at full still goes through.
      pop_ok    = Txhr_rd_en && !Txhr_empty && !flush;
      push_ok   = wr_en && (!full || pop_ok) && !flush;
      drop      = wr_en && full && !pop_ok && !flush;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      tx_data_d = tx_data_q;
      overrun_d = overrun_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            tx_data_d = mem[rd_ptr_q];
         end
         if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
         else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
         // Set has priority over clear.
         if (drop)             overrun_d = 1'b1;
         else if (overrun_clr) overrun_d = 1'b0;
      end
   end

   always_ff @(posedge baud_clk) begin
      if (push_ok && !reset) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         tx_data_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         tx_data_q <= tx_data_d;
         overrun_q <= overrun_d;
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit holding FIFO that sits directly upstream of the UART transmitter. The host side pushes bytes. The transmitter side pops one byte per frame through the `Txhr_empty` / `Txhr_rd_en` handshake and reads it from `tx_data_o`. The block decouples host write bursts from serial line rate and flags host overruns. It is clocked by the same `baud_clk` as the transmitter.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `DATA_W`, 8: entry width.

Ports:
- `baud_clk`  in  1  : sole clock; all state updates on its rising edge.
- `reset`  in  1  : synchronous, active-high reset.
- `wr_en`  in  1  : host push strobe, one entry per cycle it is high.
- `wr_data`  in  DATA_W  : host push data.
- `overrun_clr`  in  1  : clears the sticky `overrun` flag.
- `Txhr_rd_en`  in  1  : transmitter pop request, one-cycle pulse.
- `tx_data_o`  out  DATA_W  : last popped entry, held until the next pop.
- `Txhr_empty`  out  1  : high when count == 0.
- `full`  out  1  : high when count == DEPTH.
- `tx_count`  out  $clog2(DEPTH)+1  : current occupancy, 0..DEPTH.
- `overrun`  out  1  : sticky flag; a push was dropped because the FIFO was full.
- `tx_flush`  in  1  : present only with `UART_TXFIFO_FLUSH_EN`.

## Operation
**Storage**
- Circular buffer with `DEPTH` entries.
- `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Occupancy is held in a separate registered `count`.

**Push and pop rules**
- A push is accepted when `wr_en` is high and (`full` = 0 or a pop is accepted in the same cycle). An accepted push writes `wr_data` to mem[wr_ptr] and increments `wr_ptr`.
- A push with `wr_en` high, `full` high and no accepted pop is dropped. It sets `overrun` = 1 and changes nothing else.
- A pop is accepted when `Txhr_rd_en` is high and `Txhr_empty` = 0. An accepted pop loads `tx_data_o` <= mem[rd_ptr] and increments `rd_ptr`.
- A pop request while empty is ignored, and `tx_data_o` is held.

**Count and flags**
- `count` changes by +1 (push only), -1 (pop only) or 0 (both or neither).
- `Txhr_empty`, `full` and `tx_count` are decoded from the registered `count` and `tx_count` = `count`. None of them has a combinational path from `wr_en` or `Txhr_rd_en`.

**Simultaneous push and pop**
- When full: both are accepted, `count` stays at DEPTH, and the popped entry is the oldest.
- When empty: only the push is accepted, `count` goes to 1, and `tx_data_o` is unchanged.

**Overrun flag**
- `overrun_clr` clears `overrun`.
- If a dropped push and `overrun_clr` occur in the same cycle, set wins and `overrun` = 1.

**Data contract with the transmitter**
- `tx_data_o` is stable from the cycle after a pop until the next accepted pop.
- The transmitter samples it during its start bit, so a subsequent host push never disturbs an in-flight byte.

## Timing
- Reset (synchronous, `reset` high at the edge):
  - pointers = 0, `count` = 0;
  - `tx_data_o` = 0, `Txhr_empty` = 1, `full` = 0, `tx_count` = 0, `overrun` = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all entries. Any push or pop in the reset cycle is ignored.
- Push to visible: 1 cycle. After a push at edge N, `Txhr_empty` falls and `tx_count` increments after edge N.
- Pop to data: 1 cycle. `Txhr_rd_en` sampled at edge N puts the new `tx_data_o` valid after edge N, along with the updated `Txhr_empty`.
- Throughput: one push and one pop per cycle, sustained.
- No read-during-write hazard on the same entry. A pop needs count ≥ 1, so it reads an entry written in an earlier cycle.

## Configuration
- `UART_TXFIFO_FLUSH_EN` defined:
  - adds input `tx_flush`;
  - `tx_flush` high at an edge clears the pointers and `count` (so `Txhr_empty` = 1, `full` = 0);
  - `tx_data_o` and `overrun` are held;
  - flush has priority over a push or pop in the same cycle, and both are discarded.
- Macro undefined: no `tx_flush` port; the FIFO empties only by popping or by `reset`.

## Test plan
- Reset: assert `reset` 2 cycles with `wr_en` = 1 -> `Txhr_empty` = 1, `full` = 0, `tx_count` = 0, `tx_data_o` = 8'h00, `overrun` = 0, nothing stored.
- Single byte: push 8'hA5 -> next cycle `Txhr_empty` = 0 and `tx_count` = 1. Then a 1-cycle `Txhr_rd_en` -> next cycle `tx_data_o` = 8'hA5, `Txhr_empty` = 1. Then push 8'h3C with no pop -> `tx_data_o` still 8'hA5.
- Fill and overrun:
  - push 8'h00..8'h0F -> `full` = 1, `tx_count` = 16;
  - push 8'hFF -> `overrun` = 1, `tx_count` = 16;
  - 16 pops -> `tx_data_o` sequence 8'h00..8'h0F, then `Txhr_empty` = 1;
  - `overrun_clr` -> `overrun` = 0.
- Simultaneous at full: with 16 entries, push 8'h80 and pop in the same cycle -> `tx_count` stays 16, `full` stays 1, popped value is the oldest entry, and 8'h80 comes out last.
- Wrap-around: 40 bytes 8'h10..8'h37 with random push/pop interleave, never overrunning -> output order matches input exactly across pointer wrap, and `tx_count` always equals pushes minus pops.
- Flush (`UART_TXFIFO_FLUSH_EN`): 5 entries plus `tx_flush` with concurrent push -> next cycle `tx_count` = 0, `Txhr_empty` = 1, `tx_data_o` unchanged, and a subsequent pop request is ignored.
